display_refresh_scheduler: RTL

- Sequences the two_line_display_driver: holds the display reset, replays the power-up init command list, then keeps the 2-line character display in sync with an on-chip shadow buffer.
- Upstream logic writes characters into per-line shadow registers; the scheduler arbitrates round-robin between dirty lines and streams one byte at a time to the driver over a start/done handshake.
- Detects a hung driver by timeout and re-initialises.

---
 rtl/display_pkg.sv | 31 +++
 rtl/display_shadow_ram.sv | 41 ++++
 rtl/display_refresh_scheduler.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
// Module   : display_pkg
// Brief    : States, init command ROM and LCD constants for the refresh scheduler
// Revision : 1.0
// ============================================================================
package display_pkg;

    typedef enum logic [3:0] {
        ST_RST_HOLD   = 4'd0,
        ST_PWR_WAIT   = 4'd1,
        ST_INIT_ISSUE = 4'd2,
        ST_INIT_WAIT  = 4'd3,
        ST_CLR_WAIT   = 4'd4,
        ST_IDLE       = 4'd5,
        ST_ADDR_ISSUE = 4'd6,
        ST_ADDR_WAIT  = 4'd7,
        ST_CHAR_ISSUE = 4'd8,
        ST_CHAR_WAIT  = 4'd9
    } state_t;

    localparam int         INIT_LEN = 4;
    localparam logic [7:0] INIT_ROM [INIT_LEN] = '{8'h38, 8'h0C, 8'h01, 8'h06};

    localparam logic [7:0] CMD_LINE0_ADDR = 8'h80;
    localparam logic [7:0] CMD_LINE1_ADDR = 8'hC0;
    localparam logic [7:0] CMD_CLEAR      = 8'h01;
    localparam logic [7:0] CHAR_SPACE     = 8'h20;

endpackage
`default_nettype wire

// File: rtl/display_shadow_ram.sv
`default_nettype none
// ============================================================================
// Module   : display_shadow_ram
// Brief    : 2 x COLS x 8 character register file, one write / one async read
// Revision : 1.0
// ============================================================================
module display_shadow_ram
    import display_pkg::*;
#(
    parameter int COLS = 16,
    parameter int CW   = $clog2(COLS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en_i,
    input  logic          wr_line_i,
    input  logic [CW-1:0] wr_col_i,
    input  logic [7:0]    wr_char_i,
    input  logic          rd_line_i,
    input  logic [CW-1:0] rd_col_i,
    output logic [7:0]    rd_data_o
);

    logic [7:0] mem_q [2][COLS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int l = 0; l < 2; l++) begin
                for (int c = 0; c < COLS; c++) begin
                    mem_q[l][c] <= CHAR_SPACE;
                end
            end
        end else if (wr_en_i) begin
            mem_q[wr_line_i][wr_col_i] <= wr_char_i;
        end
    end

    assign rd_data_o = mem_q[rd_line_i][rd_col_i];

endmodule
`default_nettype wire

// File: rtl/display_refresh_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : display_refresh_scheduler
// Brief    : Resets/initialises a 2-line character display, then streams dirty
//            shadow lines to the byte driver with round-robin arbitration.
// Revision : 1.0
// ============================================================================
module display_refresh_scheduler
    import display_pkg::*;
#(
    parameter int COLS              = 16,
    parameter int RESET_CYCLES      = 1000,
    parameter int PWRUP_WAIT_CYCLES = 2000,
    parameter int CLEAR_WAIT_CYCLES = 100000,
    parameter int TIMEOUT_CYCLES    = 50000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en_i,
    input  logic                    wr_line_i,
    input  logic [$clog2(COLS)-1:0] wr_col_i,
    input  logic [7:0]              wr_char_i,
    input  logic                    refresh_all_i,
    output logic                    drv_rst_low_o,
    output logic                    drv_start_o,
    output logic [7:0]              drv_byte_o,
    output logic                    drv_rs_o,
    input  logic                    drv_done_i,
    output logic                    ready_o,
    output logic                    busy_o,
    output logic                    timeout_err_o
);

    localparam int CW = $clog2(COLS);

    state_t        state_q, state_d;
    logic [31:0]   cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic          line_q, line_d;
    logic [CW-1:0] col_q, col_d;
    logic          last_served_q, last_served_d;
    logic [1:0]    dirty_q, dirty_d;
    logic          ready_q, ready_d;
    logic          timeout_err_q, timeout_err_d;
    logic          rst_low_q, rst_low_d;
    logic [7:0]    byte_q, byte_d;
    logic          rs_q, rs_d;

    logic          w_wr_ok;
    logic [7:0]    w_rd_data;
    logic          w_start;
    logic [7:0]    w_byte;
    logic          w_rs;
    logic [1:0]    w_clr;
    logic [1:0]    w_set;
    logic          w_init_adv;
    logic          w_init_done;
    logic          w_timeout;

    assign w_wr_ok = wr_en_i && ({1'b0, wr_col_i} < (CW+1)'(COLS));

    display_shadow_ram #(
        .COLS (COLS),
        .CW   (CW)
    ) u_shadow (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (w_wr_ok),
        .wr_line_i (wr_line_i),
        .wr_col_i  (wr_col_i),
        .wr_char_i (wr_char_i),
        .rd_line_i (line_q),
        .rd_col_i  (col_q),
        .rd_data_o (w_rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RST_HOLD;
            cnt_q         <= '0;
            idx_q         <= '0;
            line_q        <= 1'b0;
            col_q         <= '0;
            last_served_q <= 1'b1;
            dirty_q       <= 2'b00;
            ready_q       <= 1'b0;
            timeout_err_q <= 1'b0;
            rst_low_q     <= 1'b0;
            byte_q        <= 8'h00;
            rs_q          <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            line_q        <= line_d;
            col_q         <= col_d;
            last_served_q <= last_served_d;
            dirty_q       <= dirty_d;
            ready_q       <= ready_d;
            timeout_err_q <= timeout_err_d;
            rst_low_q     <= rst_low_d;
            byte_q        <= byte_d;
            rs_q          <= rs_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        line_d        = line_q;
        col_d         = col_q;
        last_served_d = last_served_q;
        ready_d       = ready_q;
        timeout_err_d = timeout_err_q;
        rst_low_d     = rst_low_q;
        w_start       = 1'b0;
        w_byte        = byte_q;
        w_rs          = rs_q;
        w_clr         = 2'b00;
        w_set         = 2'b00;
        w_init_adv    = 1'b0;
        w_init_done   = 1'b0;
        w_timeout     = 1'b0;

        case (state_q)
            ST_RST_HOLD: begin
                rst_low_d = 1'b0;
                if (cnt_q == 32'(RESET_CYCLES - 1)) begin
                    cnt_d     = '0;
                    rst_low_d = 1'b1;
                    state_d   = ST_PWR_WAIT;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_PWR_WAIT: begin
                if (cnt_q == 32'(PWRUP_WAIT_CYCLES - 1)) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = ST_INIT_ISSUE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_INIT_ISSUE: begin
                w_start = 1'b1;
                w_byte  = INIT_ROM[idx_q];
                w_rs    = 1'b0;
                cnt_d   = '0;
                state_d = ST_INIT_WAIT;
            end
            ST_INIT_WAIT: begin
                if (drv_done_i) begin
                    if (byte_q == CMD_CLEAR) begin
                        cnt_d   = '0;
                        state_d = ST_CLR_WAIT;
                    end else begin
                        w_init_adv = 1'b1;
                    end
                end else if (cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
                    w_timeout = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_CLR_WAIT: begin
                if (cnt_q == 32'(CLEAR_WAIT_CYCLES - 1)) begin
                    w_init_adv = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_IDLE: begin
                if (dirty_q != 2'b00) begin
                    // With both lines pending, the one not served last goes first.
                    if (dirty_q == 2'b11) begin
                        line_d = ~last_served_q;
                    end else begin
                        line_d = dirty_q[1];
                    end
                    state_d = ST_ADDR_ISSUE;
                end
            end
            ST_ADDR_ISSUE: begin
                w_start       = 1'b1;
                w_byte        = line_q ? CMD_LINE1_ADDR : CMD_LINE0_ADDR;
                w_rs          = 1'b0;
                w_clr[line_q] = 1'b1;
                last_served_d = line_q;
                cnt_d         = '0;
                state_d       = ST_ADDR_WAIT;
            end
            ST_ADDR_WAIT: begin
                if (drv_done_i) begin
                    col_d   = '0;
                    state_d = ST_CHAR_ISSUE;
                end else if (cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
                    w_timeout = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_CHAR_ISSUE: begin
                w_start = 1'b1;
                w_byte  = w_rd_data;
                w_rs    = 1'b1;
                cnt_d   = '0;
                state_d = ST_CHAR_WAIT;
            end
            ST_CHAR_WAIT: begin
                if (drv_done_i) begin
                    if (col_q == CW'(COLS - 1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        col_d   = col_q + 1'b1;
                        state_d = ST_CHAR_ISSUE;
                    end
                end else if (cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
                    w_timeout = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: begin
                state_d = ST_RST_HOLD;
            end
        endcase

        if (w_init_adv) begin
            if (idx_q == 2'(INIT_LEN - 1)) begin
                ready_d     = 1'b1;
                w_init_done = 1'b1;
                state_d     = ST_IDLE;
            end else begin
                idx_d   = idx_q + 2'd1;
                state_d = ST_INIT_ISSUE;
            end
        end

        // Shadow and dirty bits survive the re-init; only the sequencer restarts.
        if (w_timeout) begin
            timeout_err_d = 1'b1;
            ready_d       = 1'b0;
            rst_low_d     = 1'b0;
            cnt_d         = '0;
            idx_d         = '0;
            state_d       = ST_RST_HOLD;
        end

        if (refresh_all_i || w_init_done) begin
            w_set = 2'b11;
        end
        if (w_wr_ok) begin
            w_set[wr_line_i] = 1'b1;
        end
    end

    // Sets are applied after clears so a same-cycle write keeps the line dirty.
    assign dirty_d = (dirty_q & ~w_clr) | w_set;
    assign byte_d  = w_byte;
    assign rs_d    = w_rs;

    assign drv_rst_low_o = rst_low_q;
    assign drv_start_o   = w_start;
    assign drv_byte_o    = w_byte;
    assign drv_rs_o      = w_rs;
    assign ready_o       = ready_q;
    assign timeout_err_o = timeout_err_q;
    assign busy_o        = !((state_q == ST_IDLE) && (dirty_q == 2'b00) && ready_q);

endmodule
`default_nettype wire
